noc_switch_allocator: RTL

Per-output switch allocator for the 5-port NoC router. It sits between the input buffers and the crossbar. It arbitrates competing input requests for each output port with per-output round-robin priority. It locks an output to one input for a whole wormhole packet and drives the buffer pop requests and crossbar selects.

---
 rtl/noc_pkg.sv | 30 +++
 rtl/noc_switch_allocator_rr_arbiter.sv | 34 +++
 rtl/noc_switch_allocator.sv | 123 ++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared constants, enums and helpers for the NoC router switch allocator.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: NUM_PORTS/SEL_W/FLIT_W, port_e (N,S,E,W,L), alloc_state_e, next_port().
package noc_pkg;

  localparam int NUM_PORTS = 5;
  localparam int SEL_W     = 3;
  localparam int FLIT_W    = 16;

  typedef enum logic [SEL_W-1:0] {
    NORTH = 3'd0,
    SOUTH = 3'd1,
    EAST  = 3'd2,
    WEST  = 3'd3,
    LOCAL = 3'd4
  } port_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_e;

  // Port index after p, wrapping LOCAL back to NORTH.
  function automatic logic [SEL_W-1:0] next_port(input logic [SEL_W-1:0] p);
    if (p >= SEL_W'(NUM_PORTS - 1)) return '0;
    return p + SEL_W'(1);
  endfunction

endpackage

// File: rtl/noc_switch_allocator_rr_arbiter.sv
// Round-robin pick among NUM_PORTS requesters starting at a pointer, wrapping 4->0.
// Latency: purely combinational.
// Backpressure: none; caller decides when the grant is consumed.
// Ports: i_req request vector, i_ptr highest-priority index, o_vld any grant, o_idx granted index.
module rr_arbiter
  import noc_pkg::*;
(
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [SEL_W-1:0]     i_ptr,
  output logic                 o_vld,
  output logic [SEL_W-1:0]     o_idx
);

  logic [SEL_W:0] w_pos;

  always_comb begin
    o_vld = 1'b0;
    o_idx = '0;
    w_pos = '0;
    // Scan from the farthest offset down to the pointer itself so the
    // requester nearest the pointer is the last one written and wins.
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      w_pos = {1'b0, i_ptr} + (SEL_W + 1)'(k);
      if (w_pos >= (SEL_W + 1)'(NUM_PORTS)) begin
        w_pos = w_pos - (SEL_W + 1)'(NUM_PORTS);
      end
      if (i_req[w_pos[SEL_W-1:0]]) begin
        o_vld = 1'b1;
        o_idx = w_pos[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/noc_switch_allocator.sv
// Per-output switch allocator: round-robin grant, output lock, buffer pops and crossbar selects.
// Latency: request seen in cycle N is granted at edge N+1; first pop in cycle N+1.
// Backpressure: a locked output holds while its owner is empty or out_ready_i is low.
// Ports: req_valid_i/req_dst_i/req_tail_i per input, out_ready_i per output;
//        pop_req_o per input, xbar_sel_o/out_valid_o per output.
// Config macro NOC_ALLOC_WORMHOLE_EN: defined = lock held until the tail flit;
//        undefined = lock released after every flit (req_tail_i ignored).
module noc_switch_allocator
  import noc_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req_valid_i,
  input  logic [NUM_PORTS-1:0][SEL_W-1:0] req_dst_i,
  input  logic [NUM_PORTS-1:0]            req_tail_i,
  input  logic [NUM_PORTS-1:0]            out_ready_i,
  output logic [NUM_PORTS-1:0]            pop_req_o,
  output logic [NUM_PORTS-1:0][SEL_W-1:0] xbar_sel_o,
  output logic [NUM_PORTS-1:0]            out_valid_o
);

  alloc_state_e                    r_state [NUM_PORTS];
  logic [NUM_PORTS-1:0][SEL_W-1:0] r_owner;
  logic [NUM_PORTS-1:0][SEL_W-1:0] r_ptr;

  logic [NUM_PORTS-1:0]                w_busy;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] w_req;
  logic [NUM_PORTS-1:0]                w_gnt_vld;
  logic [NUM_PORTS-1:0][SEL_W-1:0]     w_gnt_idx;
  logic [NUM_PORTS-1:0]                w_xfer;
  logic [NUM_PORTS-1:0]                w_release;

  // Inputs already owned by a locked output are hidden from every other
  // arbiter, which keeps pop_req_o one-hot per input even if a body flit
  // presents a different destination.
  always_comb begin
    w_busy = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (r_state[o] == LOCKED) w_busy[r_owner[o]] = 1'b1;
    end
  end

  // U-turns and out-of-range destinations (5..7) never match any output.
  always_comb begin
    w_req = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        w_req[o][i] = req_valid_i[i] && (req_dst_i[i] == SEL_W'(o)) &&
                      (i != o) && !w_busy[i];
      end
    end
  end

  always_comb begin
    w_xfer = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_xfer[o] = (r_state[o] == LOCKED) && req_valid_i[r_owner[o]] && out_ready_i[o];
    end
  end

`ifdef NOC_ALLOC_WORMHOLE_EN
  always_comb begin
    w_release = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_release[o] = w_xfer[o] && req_tail_i[r_owner[o]];
    end
  end
`else
  logic w_unused_tail;
  assign w_unused_tail = ^req_tail_i;
  assign w_release     = w_xfer;
`endif

  always_comb begin
    pop_req_o = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (w_xfer[o]) pop_req_o[r_owner[o]] = 1'b1;
    end
  end

  assign out_valid_o = w_xfer;
  assign xbar_sel_o  = r_owner;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_arb
    rr_arbiter u_arb (
      .i_req (w_req[g]),
      .i_ptr (r_ptr[g]),
      .o_vld (w_gnt_vld[g]),
      .o_idx (w_gnt_idx[g])
    );
  end

  // One FSM per output; the pointer only moves when a lock is released so
  // the priority rotates past the input that was just served.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        r_state[o] <= IDLE;
        r_owner[o] <= '0;
        r_ptr[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        case (r_state[o])
          IDLE: begin
            if (w_gnt_vld[o]) begin
              r_owner[o] <= w_gnt_idx[o];
              r_state[o] <= LOCKED;
            end
          end
          LOCKED: begin
            if (w_release[o]) begin
              r_state[o] <= IDLE;
              r_ptr[o]   <= next_port(r_owner[o]);
            end
          end
          default: r_state[o] <= IDLE;
        endcase
      end
    end
  end

endmodule
